// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard scheduler: forwarding selects,
// the PC register index and the per-stage scoreboard record.
package hazard_pkg;

  localparam int HZ_REG_W = 4;
  localparam logic [HZ_REG_W-1:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [HZ_REG_W-1:0] rn;
    logic [HZ_REG_W-1:0] rm;
    logic [HZ_REG_W-1:0] rd;
    logic                reg_write;
    logic                load;
    logic                pc_write;
  } stage_info_t;

  // The M stage beats W; the PC is never forwarded because it has its own write path.
  function automatic fwd_sel_t fwd_select(stage_info_t m, stage_info_t w,
                                          logic [HZ_REG_W-1:0] src);
    if (m.valid && m.reg_write && m.rd == src && m.rd != REG_PC)
      return FWD_M;
    else if (w.valid && w.reg_write && w.rd == src && w.rd != REG_PC)
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One scoreboard stage of the hazard scheduler; a bubble loads an empty entry.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_bubble,
  input  stage_info_t i_d,
  output stage_info_t o_q
);

  stage_info_t r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_q <= '0;
    else if (i_bubble)
      r_q <= '0;
    else
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: shadow scoreboard of E/M/W driving stalls,
// flushes, E-stage forwarding selects and a saturating load-stall counter.
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_d,
  input  logic [REG_W-1:0] rn_d,
  input  logic [REG_W-1:0] rm_d,
  input  logic [REG_W-1:0] rd_d,
  input  logic             reg_write_d,
  input  logic             load_d,
  input  logic             pc_write_d,
  input  logic             branch_taken_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [CNT_W-1:0] stall_count
);

  stage_info_t      w_dInfo;
  stage_info_t      w_e;
  stage_info_t      w_m;
  stage_info_t      w_w;
  logic             w_ldStall;
  logic             w_pcPend;
  logic             w_brTaken;
  logic             w_flushE;
  fwd_sel_t         w_fwdA;
  fwd_sel_t         w_fwdB;
  logic [CNT_W-1:0] r_stallCount;

  assign w_dInfo = '{valid:     valid_d,
                     rn:        rn_d,
                     rm:        rm_d,
                     rd:        rd_d,
                     reg_write: reg_write_d,
                     load:      load_d,
                     pc_write:  pc_write_d};

  hazard_stage_reg u_stageE (.clk(clk), .reset(reset), .i_bubble(w_flushE), .i_d(w_dInfo), .o_q(w_e));
  hazard_stage_reg u_stageM (.clk(clk), .reset(reset), .i_bubble(1'b0),     .i_d(w_e),     .o_q(w_m));
  hazard_stage_reg u_stageW (.clk(clk), .reset(reset), .i_bubble(1'b0),     .i_d(w_m),     .o_q(w_w));

  // Every control bit is qualified by the valid of the stage that owns it.
  assign w_ldStall = valid_d & w_e.valid & w_e.load & w_e.reg_write &
                     ((w_e.rd == rn_d) | (w_e.rd == rm_d));
  assign w_pcPend  = (valid_d & pc_write_d) | (w_e.valid & w_e.pc_write) |
                     (w_m.valid & w_m.pc_write);
  assign w_brTaken = branch_taken_e & w_e.valid;
  assign w_flushE  = w_ldStall | w_brTaken;

  assign w_fwdA = fwd_select(w_m, w_w, w_e.rn);
  assign w_fwdB = fwd_select(w_m, w_w, w_e.rm);

  assign stall_f = ~reset & (w_ldStall | w_pcPend);
  assign stall_d = ~reset & w_ldStall;
  assign flush_d = ~reset & (w_pcPend | (w_w.valid & w_w.pc_write) | w_brTaken);
  assign flush_e = ~reset & w_flushE;
  assign fwd_a_e = reset ? FWD_RF : w_fwdA;
  assign fwd_b_e = reset ? FWD_RF : w_fwdB;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stallCount <= '0;
    else if (w_ldStall && r_stallCount != {CNT_W{1'b1}})
      r_stallCount <= r_stallCount + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign stall_count = r_stallCount;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: directed hazard scenarios then
// randomized traffic, checked against a pipeline-level reference model.
module tb_hazard_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_d = 1'b0;
  logic [3:0]  rn_d = '0;
  logic [3:0]  rm_d = '0;
  logic [3:0]  rd_d = '0;
  logic        reg_write_d = 1'b0;
  logic        load_d = 1'b0;
  logic        pc_write_d = 1'b0;
  logic        branch_taken_e = 1'b0;

  logic        stall_f, stall_d, flush_d, flush_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [15:0] stall_count;
  logic        stall_f2, stall_d2, flush_d2, flush_e2;
  logic [1:0]  fwd_a_e2, fwd_b_e2;
  logic [1:0]  stall_count2;

  hazard_scheduler #(.REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .rn_d(rn_d), .rm_d(rm_d),
    .rd_d(rd_d), .reg_write_d(reg_write_d), .load_d(load_d),
    .pc_write_d(pc_write_d), .branch_taken_e(branch_taken_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_count(stall_count)
  );

  hazard_scheduler #(.REG_W(4), .CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .valid_d(valid_d), .rn_d(rn_d), .rm_d(rm_d),
    .rd_d(rd_d), .reg_write_d(reg_write_d), .load_d(load_d),
    .pc_write_d(pc_write_d), .branch_taken_e(branch_taken_e),
    .stall_f(stall_f2), .stall_d(stall_d2), .flush_d(flush_d2), .flush_e(flush_e2),
    .fwd_a_e(fwd_a_e2), .fwd_b_e(fwd_b_e2), .stall_count(stall_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int rn;
    int rm;
    int rd;
    bit rw;
    bit ld;
    bit pcw;
  } ins_t;

  typedef struct {
    bit sf;
    bit sd;
    bit fd;
    bit fe;
    int fa;
    int fb;
    int cnt;
    int cnt2;
  } exp_t;

  exp_t expQ[$];
  ins_t pipe[3];
  ins_t curD;
  bit   curBr;
  bit   curRst = 1'b1;
  exp_t curExp;
  int   cnt16 = 0;
  int   cntSat = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic ins_t mk(bit v, int rn, int rm, int rd, bit rw, bit ld, bit pcw);
    ins_t i;
    i.v = v; i.rn = rn; i.rm = rm; i.rd = rd; i.rw = rw; i.ld = ld; i.pcw = pcw;
    return i;
  endfunction

  function automatic ins_t nop();
    return mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endfunction

  // The newest producer of src wins; register 15 is never forwarded.
  function automatic int fwdOf(int src);
    if (src == 15) return 0;
    if (pipe[1].v && pipe[1].rw && pipe[1].rd == src) return 2;
    if (pipe[2].v && pipe[2].rw && pipe[2].rd == src) return 1;
    return 0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit ldUse, pcPending, brk;
    e = '{default: 0};
    if (curRst) return e;
    ldUse = curD.v && pipe[0].v && pipe[0].ld && pipe[0].rw &&
            (pipe[0].rd == curD.rn || pipe[0].rd == curD.rm);
    pcPending = (curD.v && curD.pcw) || (pipe[0].v && pipe[0].pcw) || (pipe[1].v && pipe[1].pcw);
    brk = curBr && pipe[0].v;
    e.sf = ldUse || pcPending;
    e.sd = ldUse;
    e.fd = pcPending || (pipe[2].v && pipe[2].pcw) || brk;
    e.fe = ldUse || brk;
    e.fa = fwdOf(pipe[0].rn);
    e.fb = fwdOf(pipe[0].rm);
    e.cnt = cnt16;
    e.cnt2 = cntSat;
    return e;
  endfunction

  task automatic advanceModel();
    if (curRst) begin
      for (int i = 0; i < 3; i++) pipe[i] = nop();
      cnt16 = 0;
      cntSat = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = curExp.fe ? nop() : curD;
      if (curExp.sd) begin
        if (cnt16 < 65535) cnt16++;
        if (cntSat < 3) cntSat++;
      end
    end
  endtask

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(ins_t d, bit br, bit rst);
    @(posedge clk);
    advanceModel();
    #1;
    reset = rst;
    valid_d = d.v;
    rn_d = 4'(d.rn);
    rm_d = 4'(d.rm);
    rd_d = 4'(d.rd);
    reg_write_d = d.rw;
    load_d = d.ld;
    pc_write_d = d.pcw;
    branch_taken_e = br;
    curD = d;
    curBr = br;
    curRst = rst;
    curExp = predict();
    expQ.push_back(curExp);
    #1;
  endtask

  // Monitor: pops the expected response for the cycle and compares both instances.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("stall_f", int'(stall_f), int'(e.sf));
      checkOutput("stall_d", int'(stall_d), int'(e.sd));
      checkOutput("flush_d", int'(flush_d), int'(e.fd));
      checkOutput("flush_e", int'(flush_e), int'(e.fe));
      checkOutput("fwd_a_e", int'(fwd_a_e), e.fa);
      checkOutput("fwd_b_e", int'(fwd_b_e), e.fb);
      checkOutput("stall_count", int'(stall_count), e.cnt);
      checkOutput("stall_count_sat", int'(stall_count2), e.cnt2);
      checkOutput("sat_flush_e", int'(flush_e2), int'(e.fe));
    end
  end

  initial begin
    ins_t d;
    bit br, rst;

    for (int i = 0; i < 3; i++) pipe[i] = nop();
    curD = nop();
    curExp = '{default: 0};

    applyStimulus(nop(), 1'b0, 1'b1);
    checkOutput("reset_stall_count", int'(stall_count), 0);
    checkOutput("reset_flush_d", int'(flush_d), 0);
    applyStimulus(nop(), 1'b0, 1'b0);

    // Forward from M
    applyStimulus(mk(1, 4, 5, 1, 1, 0, 0), 1'b0, 1'b0);
    applyStimulus(mk(1, 1, 6, 7, 1, 0, 0), 1'b0, 1'b0);
    applyStimulus(nop(), 1'b0, 1'b0);
    checkOutput("fwdM_a", int'(fwd_a_e), 2);
    checkOutput("fwdM_nostall", int'(stall_f), 0);

    // M beats W
    applyStimulus(mk(1, 0, 0, 2, 1, 0, 0), 1'b0, 1'b0);
    applyStimulus(mk(1, 0, 0, 2, 1, 0, 0), 1'b0, 1'b0);
    applyStimulus(mk(1, 8, 2, 9, 1, 0, 0), 1'b0, 1'b0);
    applyStimulus(nop(), 1'b0, 1'b0);
    checkOutput("prio_b", int'(fwd_b_e), 2);

    // Load-use
    applyStimulus(mk(1, 4, 5, 3, 1, 1, 0), 1'b0, 1'b0);
    applyStimulus(mk(1, 3, 6, 8, 1, 0, 0), 1'b0, 1'b0);
    checkOutput("lu_stall_f", int'(stall_f), 1);
    checkOutput("lu_stall_d", int'(stall_d), 1);
    checkOutput("lu_flush_e", int'(flush_e), 1);
    applyStimulus(mk(1, 3, 6, 8, 1, 0, 0), 1'b0, 1'b0);
    checkOutput("lu_count", int'(stall_count), 1);
    checkOutput("lu_release", int'(stall_d), 0);
    applyStimulus(nop(), 1'b0, 1'b0);
    checkOutput("lu_fwd_a", int'(fwd_a_e), 1);

    // Branch taken with a valid and an empty E stage
    applyStimulus(mk(1, 10, 11, 12, 1, 0, 0), 1'b0, 1'b0);
    applyStimulus(nop(), 1'b1, 1'b0);
    checkOutput("br_flush_d", int'(flush_d), 1);
    checkOutput("br_flush_e", int'(flush_e), 1);
    checkOutput("br_stall_f", int'(stall_f), 0);
    applyStimulus(nop(), 1'b0, 1'b0);
    checkOutput("br_one_cycle", int'(flush_d), 0);
    applyStimulus(nop(), 1'b1, 1'b0);
    checkOutput("br_invalid_e", int'(flush_d), 0);
    applyStimulus(nop(), 1'b0, 1'b0);
    applyStimulus(nop(), 1'b0, 1'b0);

    // PC write: 3 cycles of stall_f, 4 of flush_d
    applyStimulus(mk(1, 0, 0, 15, 1, 0, 1), 1'b0, 1'b0);
    checkOutput("pcw0_stall_f", int'(stall_f), 1);
    checkOutput("pcw0_flush_d", int'(flush_d), 1);
    for (int c = 1; c < 5; c++) begin
      applyStimulus(nop(), 1'b0, 1'b0);
      checkOutput("pcw_stall_f", int'(stall_f), (c < 3) ? 1 : 0);
      checkOutput("pcw_flush_d", int'(flush_d), (c < 4) ? 1 : 0);
    end

    // Saturation of the narrow counter, then reset in the middle of a stall
    applyStimulus(nop(), 1'b0, 1'b1);
    applyStimulus(nop(), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(mk(1, 4, 5, 3, 1, 1, 0), 1'b0, 1'b0);
      applyStimulus(mk(1, 6, 3, 8, 1, 0, 0), 1'b0, 1'b0);
      applyStimulus(mk(1, 6, 3, 8, 1, 0, 0), 1'b0, 1'b0);
    end
    checkOutput("sat_count2", int'(stall_count2), 3);
    checkOutput("sat_count16", int'(stall_count), 5);
    applyStimulus(mk(1, 4, 5, 3, 1, 1, 0), 1'b0, 1'b0);
    applyStimulus(mk(1, 3, 6, 8, 1, 0, 0), 1'b0, 1'b0);
    checkOutput("rst_pre_stall", int'(stall_d), 1);
    applyStimulus(mk(1, 3, 6, 8, 1, 0, 0), 1'b0, 1'b1);
    checkOutput("rst_stall_f", int'(stall_f), 0);
    checkOutput("rst_flush_e", int'(flush_e), 0);
    checkOutput("rst_count", int'(stall_count), 0);
    applyStimulus(nop(), 1'b0, 1'b0);

    // Random traffic; the bench acts as the datapath holding or clearing F/D
    for (int n = 0; n < 400; n++) begin
      if (!curRst && curExp.fd) begin
        d = mk(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               1'($urandom), 1'($urandom), 1'($urandom));
      end else if (!curRst && curExp.sd) begin
        d = curD;
      end else begin
        d = mk($urandom_range(0, 9) != 0,
               ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
               $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3),
               $urandom_range(0, 4) != 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 19) == 0);
      end
      br = $urandom_range(0, 9) == 0;
      rst = $urandom_range(0, 49) == 0;
      applyStimulus(d, br, rst);
    end

    applyStimulus(nop(), 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
